// File: rtl/sv_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : sv_combiner
//  Description : Sums NCHAN complex satellite channel samples, adds complex
//                pseudo-Gaussian noise from two Galois LFSRs, and saturates
//                the result to a 16-bit signed I/Q stream. Latency 4 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module sv_combiner #(
    parameter int          NCHAN    = 8,
    parameter logic [31:0] SEED_XOR = 32'hA5A5A5A5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dv_in,
    input  logic [16*NCHAN-1:0]   real_in,
    input  logic [16*NCHAN-1:0]   imag_in,
    input  logic [15:0]           noise_gain,
    input  logic [31:0]           noise_seed,
    output logic                  dv_out,
    output logic [15:0]           real_out,
    output logic [15:0]           imag_out,
    output logic [15:0]           sat_count
);

    localparam int          c_SUM_W = 16 + $clog2(NCHAN);
    localparam int          c_ACC_W = ((c_SUM_W > 17) ? c_SUM_W : 17) + 1;
    localparam logic [31:0] c_POLY  = 32'h80200003;
    localparam logic signed [c_ACC_W-1:0] c_MAX = c_ACC_W'(32767);
    localparam logic signed [c_ACC_W-1:0] c_MIN = c_ACC_W'(-32768);

    // One Galois step: shift right, fold the polynomial in when a 1 drops out
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? c_POLY : 32'h0);
    endfunction

    // An all-zero state would lock the LFSR, so it is forced to 1
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    // Sum of the four bytes as signed values: a cheap bell-shaped noise sample
    function automatic logic signed [9:0] byte_sum(input logic [31:0] s);
        logic signed [9:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            acc = acc + 10'($signed(s[8*i +: 8]));
        end
        return acc;
    endfunction

    logic [31:0]                 r_lfsr_a;
    logic [31:0]                 r_lfsr_b;
    logic [3:0]                  r_dv;

    logic [16*NCHAN-1:0]         r_re1;
    logic [16*NCHAN-1:0]         r_im1;
    logic signed [9:0]           r_na1;
    logic signed [9:0]           r_nb1;
    logic [15:0]                 r_gain1;

    logic signed [c_SUM_W-1:0]   w_sum_re;
    logic signed [c_SUM_W-1:0]   w_sum_im;
    logic signed [26:0]          w_prod_a;
    logic signed [26:0]          w_prod_b;
    logic signed [c_SUM_W-1:0]   r_sum_re2;
    logic signed [c_SUM_W-1:0]   r_sum_im2;
    logic signed [16:0]          r_nz_re2;
    logic signed [16:0]          r_nz_im2;

    logic signed [c_ACC_W-1:0]   r_acc_re3;
    logic signed [c_ACC_W-1:0]   r_acc_im3;

    logic                        w_hi_re, w_lo_re, w_hi_im, w_lo_im;
    logic [15:0]                 w_sat_re;
    logic [15:0]                 w_sat_im;
    logic [15:0]                 r_real4;
    logic [15:0]                 r_imag4;
    logic [15:0]                 r_sat_cnt;

    // Noise LFSRs: seeded during reset, consumed only by valid samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr_a <= seed_fix(noise_seed);
            r_lfsr_b <= seed_fix(noise_seed ^ SEED_XOR);
        end else if (dv_in) begin
            r_lfsr_a <= lfsr_step(r_lfsr_a);
            r_lfsr_b <= lfsr_step(r_lfsr_b);
        end
    end

    // Valid strobe travels alongside the data through four stages
    always_ff @(posedge clk) begin
        if (reset) r_dv <= '0;
        else       r_dv <= {r_dv[2:0], dv_in};
    end

    // S1: capture channel samples, gain and pre-advance noise byte sums
    always_ff @(posedge clk) begin
        if (reset) begin
            r_re1   <= '0;
            r_im1   <= '0;
            r_na1   <= '0;
            r_nb1   <= '0;
            r_gain1 <= '0;
        end else begin
            r_re1   <= real_in;
            r_im1   <= imag_in;
            r_na1   <= byte_sum(r_lfsr_a);
            r_nb1   <= byte_sum(r_lfsr_b);
            r_gain1 <= noise_gain;
        end
    end

    // Full-width channel adder tree plus noise scaling by the unsigned gain
    always_comb begin
        w_sum_re = '0;
        w_sum_im = '0;
        for (int k = 0; k < NCHAN; k++) begin
            w_sum_re = w_sum_re + c_SUM_W'($signed(r_re1[16*k +: 16]));
            w_sum_im = w_sum_im + c_SUM_W'($signed(r_im1[16*k +: 16]));
        end
        w_prod_a = 27'(r_na1) * 27'($signed({1'b0, r_gain1}));
        w_prod_b = 27'(r_nb1) * 27'($signed({1'b0, r_gain1}));
    end

    // S2: register channel sums and the 17-bit noise terms (product >> 10)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum_re2 <= '0;
            r_sum_im2 <= '0;
            r_nz_re2  <= '0;
            r_nz_im2  <= '0;
        end else begin
            r_sum_re2 <= w_sum_re;
            r_sum_im2 <= w_sum_im;
            r_nz_re2  <= 17'(w_prod_a >>> 10);
            r_nz_im2  <= 17'(w_prod_b >>> 10);
        end
    end

    // S3: add noise in an accumulator wide enough that nothing overflows
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_re3 <= '0;
            r_acc_im3 <= '0;
        end else begin
            r_acc_re3 <= c_ACC_W'(r_sum_re2) + c_ACC_W'(r_nz_re2);
            r_acc_im3 <= c_ACC_W'(r_sum_im2) + c_ACC_W'(r_nz_im2);
        end
    end

    // Clamp each component to the 16-bit signed range
    always_comb begin
        w_hi_re  = (r_acc_re3 > c_MAX);
        w_lo_re  = (r_acc_re3 < c_MIN);
        w_hi_im  = (r_acc_im3 > c_MAX);
        w_lo_im  = (r_acc_im3 < c_MIN);
        w_sat_re = w_hi_re ? 16'h7FFF : (w_lo_re ? 16'h8000 : r_acc_re3[15:0]);
        w_sat_im = w_hi_im ? 16'h7FFF : (w_lo_im ? 16'h8000 : r_acc_im3[15:0]);
    end

    // S4: output registers and clip counter, counting valid samples only
    always_ff @(posedge clk) begin
        if (reset) begin
            r_real4   <= '0;
            r_imag4   <= '0;
            r_sat_cnt <= '0;
        end else begin
            r_real4 <= w_sat_re;
            r_imag4 <= w_sat_im;
            if (r_dv[2] && (w_hi_re || w_lo_re || w_hi_im || w_lo_im) &&
                (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end

    assign dv_out    = r_dv[3];
    assign real_out  = r_real4;
    assign imag_out  = r_imag4;
    assign sat_count = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sv_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sv_combiner
//  Description : Self-checking bench for sv_combiner with a behavioural
//                reference model of the noise, summation and saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sv_combiner;

    localparam int          NCHAN    = 8;
    localparam logic [31:0] SEED_XOR = 32'hA5A5A5A5;
    localparam int          W        = 16 * NCHAN;

    logic          clk = 1'b0;
    logic          reset;
    logic          dv_in;
    logic [W-1:0]  real_in;
    logic [W-1:0]  imag_in;
    logic [15:0]   noise_gain;
    logic [31:0]   noise_seed;
    logic          dv_out;
    logic [15:0]   real_out;
    logic [15:0]   imag_out;
    logic [15:0]   sat_count;

    sv_combiner #(.NCHAN(NCHAN), .SEED_XOR(SEED_XOR)) dut (
        .clk        (clk),
        .reset      (reset),
        .dv_in      (dv_in),
        .real_in    (real_in),
        .imag_in    (imag_in),
        .noise_gain (noise_gain),
        .noise_seed (noise_seed),
        .dv_out     (dv_out),
        .real_out   (real_out),
        .imag_out   (imag_out),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    logic [31:0] m_a, m_b;
    int          m_sat;
    int q_exp_re[$], q_exp_im[$], q_exp_cyc[$];
    int q_got_re[$], q_got_im[$], q_got_cyc[$];
    int saved_re[$], saved_im[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output capture: every valid output with the cycle it appeared in
    always @(negedge clk) begin
        if (dv_out === 1'b1) begin
            q_got_re.push_back(int'($signed(real_out)));
            q_got_im.push_back(int'($signed(imag_out)));
            q_got_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic int floor_div1024(input int p);
        return (p >= 0) ? (p / 1024) : -((-p + 1023) / 1024);
    endfunction

    function automatic int noise_of(input logic [31:0] s, input logic [15:0] g);
        int bs;
        bs = 0;
        for (int i = 0; i < 4; i++) bs += int'($signed(s[8*i +: 8]));
        return floor_div1024(bs * int'(g));
    endfunction

    function automatic int clamp16(input int v);
        return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
    endfunction

    function automatic logic [W-1:0] fill(input logic [15:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < NCHAN; k++) r[16*k +: 16] = v;
        return r;
    endfunction

    task automatic clear_queues();
        q_exp_re.delete(); q_exp_im.delete(); q_exp_cyc.delete();
        q_got_re.delete(); q_got_im.delete(); q_got_cyc.delete();
    endtask

    // Drive one cycle; for valid samples predict the output and its cycle
    task automatic send(input bit v, input logic [W-1:0] re, input logic [W-1:0] im,
                        input logic [15:0] g);
        int sr, si;
        @(negedge clk);
        dv_in = v; real_in = re; imag_in = im; noise_gain = g;
        if (v) begin
            sr = noise_of(m_a, g);
            si = noise_of(m_b, g);
            m_a = lfsr_next(m_a);
            m_b = lfsr_next(m_b);
            for (int k = 0; k < NCHAN; k++) begin
                sr += int'($signed(re[16*k +: 16]));
                si += int'($signed(im[16*k +: 16]));
            end
            if ((clamp16(sr) != sr || clamp16(si) != si) && m_sat < 65535) m_sat++;
            q_exp_re.push_back(clamp16(sr));
            q_exp_im.push_back(clamp16(si));
            q_exp_cyc.push_back(cyc + 4);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, '0, '0, noise_gain);
    endtask

    task automatic do_reset(input logic [31:0] seed);
        @(negedge clk);
        reset = 1'b1; dv_in = 1'b0; noise_seed = seed;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_a   = (seed == 32'h0) ? 32'h1 : seed;
        m_b   = ((seed ^ SEED_XOR) == 32'h0) ? 32'h1 : (seed ^ SEED_XOR);
        m_sat = 0;
        clear_queues();
    endtask

    task automatic test_reset();
        do_reset(32'h1);
        @(negedge clk);
        n_tests++; if (dv_out !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", dv_out); end
        n_tests++; if (real_out !== 16'h0) begin n_fail++; $display("FAIL reset_real: got %h expected 0000", real_out); end
        n_tests++; if (imag_out !== 16'h0) begin n_fail++; $display("FAIL reset_imag: got %h expected 0000", imag_out); end
        n_tests++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL reset_sat: got %h expected 0000", sat_count); end
    endtask

    task automatic test_zero_path();
        int c0;
        do_reset(32'h1);
        noise_gain = 16'h0;
        send(1'b1, '0, '0, 16'h0);
        c0 = cyc;
        idle(8);
        n_tests++;
        if (q_got_re.size() !== 1) begin
            n_fail++; $display("FAIL zero_count: got %0d outputs expected 1", q_got_re.size());
        end else begin
            n_tests++;
            if (q_got_cyc[0] !== c0 + 4) begin n_fail++; $display("FAIL zero_latency: got cycle %0d expected %0d", q_got_cyc[0], c0 + 4); end
            n_tests++;
            if (q_got_re[0] !== 0 || q_got_im[0] !== 0) begin
                n_fail++; $display("FAIL zero_value: got (%0d,%0d) expected (0,0)", q_got_re[0], q_got_im[0]);
            end
        end
        n_tests++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL zero_sat: got %0d expected 0", sat_count); end
    endtask

    task automatic test_linear_sum();
        logic [W-1:0] re, im;
        re = '0; im = '0;
        re[15:0]  = 16'(1000);  im[15:0]  = 16'(-2000);
        re[63:48] = 16'(-250);  im[63:48] = 16'(500);
        do_reset(32'hDEADBEEF);
        for (int i = 0; i < 100; i++) send(1'b1, re, im, 16'h0);
        idle(8);
        n_tests++;
        if (q_got_re.size() !== 100) begin n_fail++; $display("FAIL linear_count: got %0d outputs expected 100", q_got_re.size()); end
        for (int i = 0; i < q_got_re.size() && i < q_exp_re.size(); i++) begin
            n_tests++;
            if (q_got_re[i] !== 750 || q_got_im[i] !== -1500 || q_got_cyc[i] !== q_exp_cyc[i]) begin
                n_fail++;
                $display("FAIL linear_sample[%0d]: got (%0d,%0d)@%0d expected (750,-1500)@%0d",
                         i, q_got_re[i], q_got_im[i], q_got_cyc[i], q_exp_cyc[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] re, im;
        logic [15:0]  g;
        do_reset($urandom);
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < NCHAN; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    re[16*k +: 16] = 16'($urandom); im[16*k +: 16] = 16'($urandom);
                end else begin
                    re[16*k +: 16] = 16'($urandom_range(0, 4095) - 2048);
                    im[16*k +: 16] = 16'($urandom_range(0, 4095) - 2048);
                end
            end
            g = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            send(($urandom_range(0, 3) != 0), re, im, g);
        end
        idle(8);
        n_tests++;
        if (q_got_re.size() !== q_exp_re.size()) begin
            n_fail++; $display("FAIL random_count: got %0d outputs expected %0d", q_got_re.size(), q_exp_re.size());
        end
        for (int i = 0; i < q_got_re.size() && i < q_exp_re.size(); i++) begin
            n_tests++;
            if (q_got_re[i] !== q_exp_re[i] || q_got_im[i] !== q_exp_im[i] || q_got_cyc[i] !== q_exp_cyc[i]) begin
                n_fail++;
                $display("FAIL random_sample[%0d]: got (%0d,%0d)@%0d expected (%0d,%0d)@%0d", i,
                         q_got_re[i], q_got_im[i], q_got_cyc[i], q_exp_re[i], q_exp_im[i], q_exp_cyc[i]);
            end
        end
        n_tests++;
        if (int'(sat_count) !== m_sat) begin n_fail++; $display("FAIL random_sat: got %0d expected %0d", sat_count, m_sat); end
    endtask

    task automatic test_saturation();
        do_reset(32'h1);
        for (int i = 0; i < 10; i++) send(1'b1, fill(16'(30000)), fill(16'(-30000)), 16'h0);
        idle(8);
        n_tests++;
        if (q_got_re.size() !== 10) begin n_fail++; $display("FAIL sat_count_out: got %0d outputs expected 10", q_got_re.size()); end
        for (int i = 0; i < q_got_re.size(); i++) begin
            n_tests++;
            if (q_got_re[i] !== 32767 || q_got_im[i] !== -32768) begin
                n_fail++; $display("FAIL sat_value[%0d]: got (%0d,%0d) expected (32767,-32768)", i, q_got_re[i], q_got_im[i]);
            end
        end
        n_tests++;
        if (sat_count !== 16'd10) begin n_fail++; $display("FAIL sat_counter: got %0d expected 10", sat_count); end
    endtask

    // Runs directly after test_saturation so the counter is non-zero going in
    task automatic test_reset_midstream();
        clear_queues();
        send(1'b1, fill(16'(30000)), fill(16'(30000)), 16'h0);
        send(1'b1, fill(16'(30000)), fill(16'(30000)), 16'h0);
        @(negedge clk);
        reset = 1'b1; dv_in = 1'b1; noise_seed = 32'h1;
        @(negedge clk);
        n_tests++; if (dv_out !== 1'b0) begin n_fail++; $display("FAIL mid_dv: got %b expected 0", dv_out); end
        n_tests++; if (real_out !== 16'h0 || imag_out !== 16'h0) begin
            n_fail++; $display("FAIL mid_data: got (%h,%h) expected (0000,0000)", real_out, imag_out);
        end
        n_tests++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL mid_sat: got %0d expected 0", sat_count); end
        reset = 1'b0; dv_in = 1'b0;
        m_a = 32'h1; m_b = 32'h1 ^ SEED_XOR; m_sat = 0;
        clear_queues();
        idle(10);
        n_tests++;
        if (q_got_re.size() !== 0) begin n_fail++; $display("FAIL mid_stale: got %0d outputs expected 0", q_got_re.size()); end
        n_tests++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL mid_sat_after: got %0d expected 0", sat_count); end
    endtask

    task automatic test_noise_determinism();
        // Reference sequence from the model
        do_reset(32'h12345678);
        for (int i = 0; i < 1000; i++) send(1'b1, '0, '0, 16'hFFFF);
        idle(8);
        n_tests++;
        if (q_got_re.size() !== 1000) begin n_fail++; $display("FAIL noise_count: got %0d outputs expected 1000", q_got_re.size()); end
        for (int i = 0; i < q_got_re.size() && i < q_exp_re.size(); i++) begin
            n_tests++;
            if (q_got_re[i] !== q_exp_re[i] || q_got_im[i] !== q_exp_im[i]) begin
                n_fail++; $display("FAIL noise_sample[%0d]: got (%0d,%0d) expected (%0d,%0d)", i,
                                   q_got_re[i], q_got_im[i], q_exp_re[i], q_exp_im[i]);
            end
        end
        saved_re = q_exp_re; saved_im = q_exp_im;
        // Same seed again, now with gaps: valid outputs must repeat exactly
        do_reset(32'h12345678);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(1'b1, '0, '0, 16'hFFFF);
        end
        idle(8);
        n_tests++;
        if (q_got_re.size() !== 1000) begin n_fail++; $display("FAIL noise_gap_count: got %0d outputs expected 1000", q_got_re.size()); end
        for (int i = 0; i < q_got_re.size() && i < saved_re.size(); i++) begin
            n_tests++;
            if (q_got_re[i] !== saved_re[i] || q_got_im[i] !== saved_im[i]) begin
                n_fail++; $display("FAIL noise_repeat[%0d]: got (%0d,%0d) expected (%0d,%0d)", i,
                                   q_got_re[i], q_got_im[i], saved_re[i], saved_im[i]);
            end
        end
        // Seed 0 must run the real-noise LFSR exactly as seed 1 does
        do_reset(32'h1);
        for (int i = 0; i < 50; i++) send(1'b1, '0, '0, 16'hFFFF);
        idle(8);
        saved_re = q_got_re;
        do_reset(32'h0);
        for (int i = 0; i < 50; i++) send(1'b1, '0, '0, 16'hFFFF);
        idle(8);
        n_tests++;
        if (q_got_re.size() !== 50 || saved_re.size() !== 50) begin
            n_fail++; $display("FAIL seed0_count: got %0d/%0d outputs expected 50/50", q_got_re.size(), saved_re.size());
        end
        for (int i = 0; i < q_got_re.size() && i < saved_re.size() && i < q_exp_re.size(); i++) begin
            n_tests++;
            if (q_got_re[i] !== saved_re[i] || q_got_re[i] !== q_exp_re[i] || q_got_im[i] !== q_exp_im[i]) begin
                n_fail++; $display("FAIL seed0_sample[%0d]: got (%0d,%0d) expected (%0d,%0d) seed1 real %0d", i,
                                   q_got_re[i], q_got_im[i], q_exp_re[i], q_exp_im[i], saved_re[i]);
            end
        end
    endtask

    task automatic test_sat_ceiling();
        do_reset(32'h1);
        for (int i = 0; i < 65540; i++) begin
            send(1'b1, fill(16'(30000)), fill(16'(-30000)), 16'h0);
            if (i == 65530) begin
                n_tests++;
                if (int'(sat_count) > 65535 || sat_count === 16'hFFFF) begin
                    n_fail++; $display("FAIL ceil_early: got %0d expected below 65535", sat_count);
                end
            end
        end
        idle(8);
        n_tests++;
        if (sat_count !== 16'hFFFF) begin n_fail++; $display("FAIL ceil_value: got %h expected ffff", sat_count); end
        n_tests++;
        if (q_got_re.size() !== 65540) begin n_fail++; $display("FAIL ceil_outputs: got %0d expected 65540", q_got_re.size()); end
        clear_queues();
    endtask

    initial begin
        reset = 1'b1; dv_in = 1'b0; real_in = '0; imag_in = '0;
        noise_gain = 16'h0; noise_seed = 32'h1;
        m_a = 32'h1; m_b = 32'h1; m_sat = 0;
        test_reset();
        test_zero_path();
        test_linear_sum();
        test_random();
        test_saturation();
        test_reset_midstream();
        test_noise_determinism();
        test_sat_ceiling();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
